// File: rtl/snake_engine.sv
`timescale 1ns/1ps
// snake_engine: ring-buffered snake core stepping once per 10 Hz tick; emits per-cell draw/erase events.
// Build option SNAKE_WRAP_EN: playfield edges wrap around instead of ending the game.
module snake_engine #(
    parameter int GRID_COLS = 40,
    parameter int GRID_ROWS = 30,
    parameter int COORD_W   = 6,
    parameter int MAX_LEN   = 64,
    parameter int INIT_LEN  = 5,
    parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_10hz,
    input  logic               reset_n,
    input  logic [3:0]         dpad,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic               draw_valid,
    output logic [COORD_W-1:0] tail_x,
    output logic [COORD_W-1:0] tail_y,
    output logic               erase_valid,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               food_valid,
    output logic [LEN_W-1:0]   length,
    output logic [15:0]        score,
    output logic               running,
    output logic               game_over
);

    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_COLS - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_ROWS - 1);
    localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);
`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t             state_q, state_d;
    dir_t               dir_q, dir_n;
    logic [COORD_W-1:0] body_x_q [MAX_LEN];
    logic [COORD_W-1:0] body_y_q [MAX_LEN];
    logic [PTR_W-1:0]   head_ptr_q, ptr_nxt, tail_idx;
    logic [LEN_W-1:0]   len_q;
    logic [15:0]        score_q;
    logic [COORD_W-1:0] head_x_q, head_y_q, tail_x_q, tail_y_q, food_x_q, food_y_q;
    logic               draw_q, erase_q, food_valid_q;
    logic [15:0]        lfsr_q, lfsr_d;

    logic [COORD_W-1:0] nx, ny, cand_x, cand_y;
    logic               off_grid, wall_hit, hit_body, grow, collide, cand_on_body, cand_ok;

    // Priority up > down > left > right; an opposite request blocks the lower-priority bits.
    function automatic dir_t next_dir(input dir_t cur, input logic [3:0] pad);
        if (pad[0])      return (cur == D_DOWN)  ? cur : D_UP;
        else if (pad[1]) return (cur == D_UP)    ? cur : D_DOWN;
        else if (pad[2]) return (cur == D_RIGHT) ? cur : D_LEFT;
        else if (pad[3]) return (cur == D_LEFT)  ? cur : D_RIGHT;
        else             return cur;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign cand_x = lfsr_q[COORD_W-1:0];
    assign cand_y = lfsr_q[COORD_W+7:8];

    // Next head, always computed with wrap-around; off_grid flags the wall crossing.
    always_comb begin
        dir_n    = next_dir(dir_q, dpad);
        nx       = head_x_q;
        ny       = head_y_q;
        off_grid = 1'b0;
        case (dir_n)
            D_UP: begin
                if (head_y_q == '0) begin off_grid = 1'b1; ny = Y_MAX; end
                else ny = head_y_q - ONE_C;
            end
            D_DOWN: begin
                if (head_y_q == Y_MAX) begin off_grid = 1'b1; ny = '0; end
                else ny = head_y_q + ONE_C;
            end
            D_LEFT: begin
                if (head_x_q == '0) begin off_grid = 1'b1; nx = X_MAX; end
                else nx = head_x_q - ONE_C;
            end
            default: begin
                if (head_x_q == X_MAX) begin off_grid = 1'b1; nx = '0; end
                else nx = head_x_q + ONE_C;
            end
        endcase
        wall_hit = off_grid & ~WRAP_EN;
        grow     = food_valid_q && (nx == food_x_q) && (ny == food_y_q);
    end

    // Ring bookkeeping and body scans; segment age 0 is the head, len-1 the tail.
    always_comb begin
        int age;
        int t;
        age          = 0;
        t            = int'(head_ptr_q) - (int'(len_q) - 1);
        if (t < 0) t = t + MAX_LEN;
        tail_idx     = PTR_W'(t);
        ptr_nxt      = (head_ptr_q == PTR_W'(MAX_LEN - 1)) ? '0 : head_ptr_q + PTR_W'(1);
        hit_body     = 1'b0;
        cand_on_body = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            age = int'(head_ptr_q) - i;
            if (age < 0) age = age + MAX_LEN;
            if (age < int'(len_q)) begin
                if (body_x_q[i] == nx && body_y_q[i] == ny &&
                    !(age == int'(len_q) - 1 && !grow))
                    hit_body = 1'b1;
                if (body_x_q[i] == cand_x && body_y_q[i] == cand_y)
                    cand_on_body = 1'b1;
            end
        end
        collide = wall_hit | hit_body;
        cand_ok = (cand_x <= X_MAX) && (cand_y <= Y_MAX) && !cand_on_body &&
                  !((cand_x == nx) && (cand_y == ny));
    end

    always_ff @(posedge clk_10hz or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dpad != 4'b0000) state_d = S_RUN;
            S_RUN:   if (collide || (grow && len_q == LEN_W'(MAX_LEN - 1))) state_d = S_DEAD;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        running   = (state_q == S_RUN);
        game_over = (state_q == S_DEAD);
    end

    always_ff @(posedge clk_10hz or negedge reset_n) begin
        if (!reset_n) begin
            dir_q <= D_RIGHT;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x_q[i] <= (i < INIT_LEN) ? COORD_W'(GRID_COLS / 2 + i) : '0;
                body_y_q[i] <= (i < INIT_LEN) ? COORD_W'(GRID_ROWS / 2) : '0;
            end
            head_ptr_q   <= PTR_W'(INIT_LEN - 1);
            len_q        <= LEN_W'(INIT_LEN);
            score_q      <= '0;
            head_x_q     <= COORD_W'(GRID_COLS / 2 + INIT_LEN - 1);
            head_y_q     <= COORD_W'(GRID_ROWS / 2);
            tail_x_q     <= '0;
            tail_y_q     <= '0;
            draw_q       <= 1'b0;
            erase_q      <= 1'b0;
            food_x_q     <= COORD_W'(GRID_COLS / 4);
            food_y_q     <= COORD_W'(GRID_ROWS / 4);
            food_valid_q <= 1'b1;
            lfsr_q       <= 16'hACE1;
        end else begin
            lfsr_q  <= lfsr_d;
            draw_q  <= 1'b0;
            erase_q <= 1'b0;
            if (state_q == S_IDLE && dpad != 4'b0000) dir_q <= dir_n;
            if (state_q == S_RUN) begin
                dir_q <= dir_n;
                if (!collide) begin
                    body_x_q[ptr_nxt] <= nx;
                    body_y_q[ptr_nxt] <= ny;
                    head_ptr_q        <= ptr_nxt;
                    head_x_q          <= nx;
                    head_y_q          <= ny;
                    draw_q            <= 1'b1;
                    if (grow) begin
                        len_q        <= len_q + LEN_W'(1);
                        score_q      <= sat_inc16(score_q);
                        food_valid_q <= 1'b0;
                    end else begin
                        tail_x_q <= body_x_q[tail_idx];
                        tail_y_q <= body_y_q[tail_idx];
                        erase_q  <= 1'b1;
                    end
                end
                if (!food_valid_q && cand_ok) begin
                    food_x_q     <= cand_x;
                    food_y_q     <= cand_y;
                    food_valid_q <= 1'b1;
                end
            end
        end
    end

    assign head_x      = head_x_q;
    assign head_y      = head_y_q;
    assign draw_valid  = draw_q;
    assign tail_x      = tail_x_q;
    assign tail_y      = tail_y_q;
    assign erase_valid = erase_q;
    assign food_x      = food_x_q;
    assign food_y      = food_y_q;
    assign food_valid  = food_valid_q;
    assign length      = len_q;
    assign score       = score_q;

endmodule
